// File: rtl/sec_decode_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sec_decode_pkg
// Shared definitions for the SEC decoder arbiter slice: the arbiter FSM state
// encoding and the default decoder word widths.
// ---------------------------------------------------------------------------
package sec_decode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int SEC_W_BITS = 61;
  localparam int SEC_N_BITS = 53;

  // Largest value the decoder reports on N (2^52 - 1).
  localparam logic [SEC_N_BITS-1:0] SEC_ALL_ONES_N = 53'h0F_FFFF_FFFF_FFFF;

endpackage

// File: rtl/sec_decode_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: the first asserted req bit found searching
// upward from ptr, wrapping from N-1 back to 0 (N need not be a power of 2).
//
// Ports:
//   req     in  [N-1:0]  request vector
//   ptr     in  [IW-1:0] highest-priority index this cycle (must be < N)
//   gnt     out [N-1:0]  one-hot grant, zero when no request
//   gnt_idx out [IW-1:0] index of the granted bit (0 when no request)
//   any     out          at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  always_comb begin : p_pick
    int j;
    j       = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      // Candidate index ptr+k, wrapped explicitly rather than by bit overflow.
      j = int'(ptr) + k;
      if (j >= N) begin
        j = j - N;
      end
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sec_decode_arbiter.sv
// ---------------------------------------------------------------------------
// sec_decode_arbiter
// Shares one clocked SEC decoder between NUM_REQ requesters. A request word is
// accepted round-robin, the decoder is restarted with a one-cycle reset pulse,
// and the arbiter waits (bounded by TIMEOUT cycles) for found before returning
// the decoded N, or an error, to the requester that was granted.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. req_ready is only offered in IDLE; rsp_valid, rsp_N and rsp_err
// are held unchanged until rsp_ready of the granted requester is sampled high.
//
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   req_valid    [NUM_REQ]          per-requester request valid
//   req_W        [NUM_REQ*W_BITS]   request words, slice i*W_BITS +: W_BITS
//   req_ready    [NUM_REQ]          one-hot accept (combinational)
//   rsp_valid    [NUM_REQ]          one-hot response valid
//   rsp_ready    [NUM_REQ]          per-requester response accept
//   rsp_N        [N_BITS]           decoded word (0 on error)
//   rsp_err                         1 = decoder timed out
//   dec_rst_n                       decoder reset (restart pulse + system reset)
//   dec_W        [W_BITS]           decoder input word
//   dec_found, dec_N                decoder outputs
//   busy                            not in IDLE
// ---------------------------------------------------------------------------
module sec_decode_arbiter
  import sec_decode_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int W_BITS  = SEC_W_BITS,
  parameter int N_BITS  = SEC_N_BITS,
  parameter int TIMEOUT = 128
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*W_BITS-1:0] req_W,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  input  logic [NUM_REQ-1:0]        rsp_ready,
  output logic [N_BITS-1:0]         rsp_N,
  output logic                      rsp_err,
  output logic                      dec_rst_n,
  output logic [W_BITS-1:0]         dec_W,
  input  logic                      dec_found,
  input  logic [N_BITS-1:0]         dec_N,
  output logic                      busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] LAST_REQ  = IW'(NUM_REQ - 1);

  state_t              r_state;
  logic [IW-1:0]       r_rr_ptr;
  logic [IW-1:0]       r_gnt_q;
  logic [W_BITS-1:0]   r_w_q;
  logic [N_BITS-1:0]   r_n_q;
  logic                r_err_q;
  logic [CW-1:0]       r_wait_cnt;

  logic [NUM_REQ-1:0]  w_arb_gnt;
  logic [IW-1:0]       w_arb_idx;
  logic                w_arb_any;
  logic                w_idle;
  logic                w_resp;
  logic [W_BITS-1:0]   w_req_word;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .gnt     (w_arb_gnt),
    .gnt_idx (w_arb_idx),
    .any     (w_arb_any)
  );

  assign w_idle = (r_state == ST_IDLE);
  assign w_resp = (r_state == ST_RESP);

  // Word of the granted requester; selected by the one-hot grant.
  always_comb begin
    w_req_word = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_arb_gnt[i]) begin
        w_req_word = req_W[i*W_BITS +: W_BITS];
      end
    end
  end

  // Nothing is accepted while the block is being reset.
  assign req_ready = (w_idle && rst_n) ? w_arb_gnt : '0;

  always_comb begin
    rsp_valid = '0;
    if (w_resp) begin
      rsp_valid[r_gnt_q] = 1'b1;
    end
  end

  assign rsp_N   = w_resp ? r_n_q : '0;
  assign rsp_err = w_resp ? r_err_q : 1'b0;

  // The decoder is held in reset with the system and pulsed for the single
  // LAUNCH cycle to start a fresh decode of r_w_q.
  assign dec_rst_n = rst_n && (r_state != ST_LAUNCH);
  assign dec_W     = r_w_q;
  assign busy      = !w_idle;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_gnt_q    <= '0;
      r_w_q      <= '0;
      r_n_q      <= '0;
      r_err_q    <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_arb_any) begin
            r_w_q   <= w_req_word;
            r_gnt_q <= w_arb_idx;
            r_state <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          // dec_found is left over from the previous decode here; ignore it.
          r_wait_cnt <= '0;
          r_state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // found takes priority over a timeout in the same cycle.
          if (dec_found) begin
            r_n_q   <= dec_N;
            r_err_q <= 1'b0;
            r_state <= ST_RESP;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_n_q   <= '0;
            r_err_q <= 1'b1;
            r_state <= ST_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready[r_gnt_q]) begin
            r_rr_ptr <= (r_gnt_q == LAST_REQ) ? '0 : r_gnt_q + 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sec_decode_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sec_decode_arbiter
// Directed bench for sec_decode_arbiter (NUM_REQ=4, TIMEOUT=8) with a
// behavioural decoder that raises found in its D-th cycle out of reset.
// A transaction-level model predicts every output each cycle; scenario
// checks pin latencies, grant order and held values to literal numbers.
// ---------------------------------------------------------------------------
module tb_sec_decode_arbiter;
  import sec_decode_pkg::*;

  localparam int NR = 4;
  localparam int WB = SEC_W_BITS;
  localparam int NB = SEC_N_BITS;
  localparam int TO = 8;
  localparam logic [NB-1:0] N_FOUND = 53'd4503599627370495;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid;
  logic [NR*WB-1:0] req_W;
  logic [NR-1:0]    req_ready;
  logic [NR-1:0]    rsp_valid;
  logic [NR-1:0]    rsp_ready;
  logic [NB-1:0]    rsp_N;
  logic             rsp_err;
  logic             dec_rst_n;
  logic [WB-1:0]    dec_W;
  logic             dec_found;
  logic [NB-1:0]    dec_N;
  logic             busy;

  sec_decode_arbiter #(
    .NUM_REQ (NR),
    .W_BITS  (WB),
    .N_BITS  (NB),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_W     (req_W),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_N     (rsp_N),
    .rsp_err   (rsp_err),
    .dec_rst_n (dec_rst_n),
    .dec_W     (dec_W),
    .dec_found (dec_found),
    .dec_N     (dec_N),
    .busy      (busy)
  );

  // ---------------- behavioural decoder ----------------
  // dec_d = 0 means found never rises. found stays high once reached, so it
  // is still high (stale) during the next restart pulse.
  int dec_d   = 5;
  int dec_cnt = 0;
  always @(posedge clk) begin
    if (!dec_rst_n) dec_cnt <= 0;
    else if (dec_cnt < 1000) dec_cnt <= dec_cnt + 1;
  end
  assign dec_found = (dec_d != 0) && (dec_cnt >= dec_d - 1);
  assign dec_N     = dec_found ? N_FOUND : '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [NR-1:0] v, input int p);
    int j;
    for (int k = 0; k < NR; k++) begin
      j = (p + k) % NR;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic int oh_idx(input logic [NR-1:0] v);
    for (int k = 0; k < NR; k++) begin
      if (v[k]) return k;
    end
    return -1;
  endfunction

  // Events observed on the DUT pins
  int            acc_who_q[$];
  int            acc_cyc_q[$];
  int            rsp_who_q[$];
  int            rsp_cyc_q[$];
  logic [NB-1:0] rsp_n_q[$];
  logic          rsp_err_q[$];
  logic [NR-1:0] prev_rv = '0;
  int            low_cnt = 0;

  // Expected grant order for the round-robin scenario
  logic [1:0] exp_q[$];

  // ---------------- transaction model ----------------
  // Phase: -1 unknown (before first reset), 0 idle, 1 restart pulse,
  // 2 waiting (m_k = wait cycle number), 3 response pending.
  int            m_phase = -1;
  int            m_owner = 0;
  int            m_ptr   = 0;
  int            m_k     = 0;
  logic [WB-1:0] m_word  = '0;
  logic [NB-1:0] m_n     = '0;
  logic          m_err   = 1'b0;
  logic [NR-1:0] e_rv;
  logic [NR-1:0] e_rr;
  int            e_pick;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && ((req_valid & req_ready) != '0)) begin
        acc_who_q.push_back(oh_idx(req_ready));
        acc_cyc_q.push_back(cyc);
      end
      if ((rsp_valid != '0) && (prev_rv == '0)) begin
        rsp_who_q.push_back(oh_idx(rsp_valid));
        rsp_cyc_q.push_back(cyc);
        rsp_n_q.push_back(rsp_N);
        rsp_err_q.push_back(rsp_err);
      end
      prev_rv = rsp_valid;
      if (rst_n && !dec_rst_n) low_cnt++;

      if (m_phase >= 0) begin
        e_rv = '0;
        if (m_phase == 3) e_rv[m_owner] = 1'b1;
        chk("busy", busy, (m_phase != 0));
        chk("dec_rst_n", dec_rst_n, (rst_n && (m_phase != 1)));
        chk("dec_W", dec_W, m_word);
        chk("rsp_valid", rsp_valid, e_rv);
        if (m_phase == 3) begin
          chk("rsp_N", rsp_N, m_n);
          chk("rsp_err", rsp_err, m_err);
        end
        if (rst_n) begin
          e_rr   = '0;
          e_pick = rr_pick(req_valid, m_ptr);
          if (m_phase == 0 && e_pick >= 0) e_rr[e_pick] = 1'b1;
          chk("req_ready", req_ready, e_rr);
        end
      end

      // What the coming rising edge does
      if (!rst_n) begin
        m_phase = 0; m_ptr = 0; m_owner = 0; m_k = 0;
        m_word = '0; m_n = '0; m_err = 1'b0;
      end else if (m_phase == 0) begin
        e_pick = rr_pick(req_valid, m_ptr);
        if (e_pick >= 0) begin
          m_owner = e_pick;
          m_word  = req_W[e_pick*WB +: WB];
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        m_phase = 2;
        m_k     = 1;
      end else if (m_phase == 2) begin
        if (dec_found) begin
          m_n = dec_N; m_err = 1'b0; m_phase = 3;
        end else if (m_k == TO) begin
          m_n = '0; m_err = 1'b1; m_phase = 3;
        end else begin
          m_k++;
        end
      end else if (m_phase == 3) begin
        if (rsp_ready[m_owner]) begin
          m_phase = 0;
          m_ptr   = (m_owner + 1) % NR;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_req(input int idx, input logic [WB-1:0] w);
    int  n;
    bit  got;
    @(posedge clk); #1;
    req_W[idx*WB +: WB] = w;
    req_valid[idx]      = 1'b1;
    got = 1'b0;
    n   = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      if (req_ready[idx]) got = 1'b1;
      n++;
    end
    chk("req_accepted", got, 1);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Checks the single response of a scenario against literal values.
  task automatic chk_rsp(input string nm, input int ba, input int br, input int who,
                         input int lat, input logic [NB-1:0] n_exp, input logic err_exp);
    chk({nm, "_rsp_count"}, rsp_who_q.size() - br, 1);
    if (rsp_who_q.size() > br && acc_cyc_q.size() > ba) begin
      chk({nm, "_rsp_who"}, rsp_who_q[br], who);
      chk({nm, "_latency"}, rsp_cyc_q[br] - acc_cyc_q[ba] - 1, lat);
      chk({nm, "_rsp_N"}, rsp_n_q[br], n_exp);
      chk({nm, "_rsp_err"}, rsp_err_q[br], err_exp);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int ba, br, bl, n;
    logic [WB-1:0] w4;

    req_valid = '0;
    req_W     = '0;
    rsp_ready = '1;
    dec_d     = 5;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_N", rsp_N, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_dec_W", dec_W, 0);
    chk("rst_dec_rst_n", dec_rst_n, 0);
    chk("rst_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single request, D=5: rsp_valid after E6
    ba = acc_who_q.size(); br = rsp_who_q.size(); bl = low_cnt;
    do_req(0, 61'd123);
    wait_neg(12);
    chk("s1_accept_who", (acc_who_q.size() > ba) ? acc_who_q[ba] : -1, 0);
    chk_rsp("s1", ba, br, 0, 6, N_FOUND, 1'b0);
    chk("s1_dec_W", dec_W, 123);
    chk("s1_dec_rst_pulse", low_cnt - bl, 1);

    // Round-robin from reset with all requesters valid, D=2
    dec_d = 2;
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < NR; i++) req_W[i*WB +: WB] = WB'(1000 + i);
    req_valid = '1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    ba = acc_who_q.size();
    n  = 0;
    while ((acc_who_q.size() - ba) < 6 && n < 80) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_neg(10);
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    chk("s2_accepts", acc_who_q.size() - ba, 6);
    if (acc_who_q.size() - ba >= 6) begin
      for (int k = 0; k < 6; k++) begin
        chk("s2_grant", acc_who_q[ba+k], exp_q.pop_front());
        if (k > 0) chk("s2_period", acc_cyc_q[ba+k] - acc_cyc_q[ba+k-1], 5);
      end
    end

    // Timeout: found never rises, rsp after E9
    dec_d = 0;
    ba = acc_who_q.size(); br = rsp_who_q.size();
    do_req(2, 61'h1_2345_6789_ABCD);
    wait_neg(14);
    chk_rsp("s3", ba, br, 2, TO + 1, '0, 1'b1);

    // Found coincides with the last WAIT cycle: found wins
    dec_d = TO;
    w4 = {$urandom, $urandom};
    ba = acc_who_q.size(); br = rsp_who_q.size();
    do_req(3, w4);
    wait_neg(14);
    chk_rsp("s4", ba, br, 3, TO + 1, N_FOUND, 1'b0);
    chk("s4_dec_W", dec_W, w4);

    // Backpressure: requester 1 response held 10 cycles, requester 2 waiting
    dec_d = 3;
    rsp_ready = 4'b1101;
    do_req(1, 61'h0ABC);
    req_W[2*WB +: WB] = 61'h2222;
    req_valid[2] = 1'b1;
    n = 0;
    while (!rsp_valid[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("s5_rsp_seen", rsp_valid[1], 1);
    for (int k = 0; k < 10; k++) begin
      chk("s5_hold_rsp_valid", rsp_valid, 4'b0010);
      chk("s5_hold_rsp_N", rsp_N, N_FOUND);
      chk("s5_hold_rsp_err", rsp_err, 0);
      chk("s5_hold_req_ready", req_ready, 0);
      chk("s5_hold_dec_rst_n", dec_rst_n, 1);
      @(negedge clk);
    end
    @(posedge clk); #1;
    rsp_ready = '1;
    ba = acc_who_q.size();
    n  = 0;
    while (acc_who_q.size() == ba && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    chk("s5_next_who", (acc_who_q.size() > ba) ? acc_who_q[ba] : -1, 2);
    wait_neg(12);

    // Reset during WAIT cycle 3 drops the request
    dec_d = 0;
    br = rsp_who_q.size();
    do_req(3, 61'h55);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("s6_dec_rst_n_in_reset", dec_rst_n, 0);
    @(negedge clk);
    chk("s6_busy", busy, 0);
    chk("s6_rsp_valid", rsp_valid, 0);
    chk("s6_rsp_N", rsp_N, 0);
    chk("s6_rsp_err", rsp_err, 0);
    chk("s6_dec_W", dec_W, 0);
    chk("s6_dec_rst_n", dec_rst_n, 0);
    chk("s6_req_ready", req_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dec_d = 2;
    req_W[0*WB +: WB] = 61'h77;
    req_valid = 4'b1001;
    ba = acc_who_q.size();
    n  = 0;
    while (acc_who_q.size() == ba && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid = '0;
    chk("s6_next_who", (acc_who_q.size() > ba) ? acc_who_q[ba] : -1, 0);
    wait_neg(12);
    chk("s6_rsp_count", rsp_who_q.size() - br, 1);
    chk("s6_rsp_who", (rsp_who_q.size() > br) ? rsp_who_q[br] : -1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sec_decode_arbiter.md
# sec_decode_arbiter

Shares a single clocked SEC decoder instance (`SECdecoder_AWE_52bits_clk`) between `NUM_REQ` requesters. Each requester hands over a 61-bit word through a valid/ready handshake. The arbiter:
- picks one requester round-robin;
- re-launches the decoder by pulsing its reset;
- waits for `found`, bounded by a timeout;
- returns the 53-bit result, or an error, to the granted requester.

It sits between the requester-side logic and the decoder; the decoder's `clk` connects directly to `clk`, and its `rst_n` connects only to `dec_rst_n`.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `W_BITS`, default 61: decoder input width.
- `N_BITS`, default 53: decoder output width.
- `TIMEOUT`, default 128: maximum number of WAIT cycles before an error response, ≥2.

Ports:
- `clk` in 1: the only clock.
- `rst_n` in 1: synchronous reset, active-low.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_W` in `NUM_REQ*W_BITS`: request words; requester i occupies bits [i*W_BITS +: W_BITS].
- `req_ready` out `NUM_REQ`: one-hot or zero; marks the requester accepted this cycle.
- `rsp_valid` out `NUM_REQ`: one-hot or zero; the response is for that requester.
- `rsp_ready` in `NUM_REQ`: per-requester response accept.
- `rsp_N` out `N_BITS`: decoded result (0 on error).
- `rsp_err` out 1: 1 = timeout, no `found`.
- `dec_rst_n` out 1: to decoder `rst_n`.
- `dec_W` out `W_BITS`: to decoder `W`.
- `dec_found` in 1: from decoder `found`.
- `dec_N` in `N_BITS`: from decoder `N`.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE → LAUNCH → WAIT → RESP → IDLE.
- **IDLE**
  - `dec_rst_n`=1.
  - Grant = the first requester with `req_valid`=1, searching from `rr_ptr` upward modulo `NUM_REQ`.
  - `req_ready` is asserted combinationally for the grant only.
  - On the handshake: latch `req_W` slice into `w_q`, latch the grant index into `gnt_q`, and go to LAUNCH.
  - With no `req_valid`, stay in IDLE.
- **LAUNCH** (exactly 1 cycle)
  - `dec_rst_n`=0; `dec_W`=`w_q`.
  - Clear `wait_cnt`.
  - `dec_found` is ignored (stale).
  - Go to WAIT.
- **WAIT**
  - `dec_rst_n`=1; `dec_W`=`w_q`, held stable.
  - Each cycle:
    - If `dec_found`=1: capture `dec_N` into `n_q`, set `err_q`=0, go to RESP.
    - Else if `wait_cnt`==`TIMEOUT`-1: set `n_q`=0, `err_q`=1, go to RESP.
    - Else: increment `wait_cnt`.
  - If `dec_found` and the timeout coincide, `found` wins (`err_q`=0).
- **RESP**
  - `rsp_valid[gnt_q]`=1; `rsp_N`=`n_q`; `rsp_err`=`err_q`. All are held until `rsp_ready[gnt_q]`=1.
  - On the handshake: `rr_ptr` ← (`gnt_q`+1) mod `NUM_REQ`, and go to IDLE.
  - `rsp_ready` bits of other requesters are ignored.
- Only one request is in flight at a time. `req_ready` is 0 in every state except IDLE.
- `wait_cnt` width is `$clog2(TIMEOUT)` and it never wraps.
- `rr_ptr` width is `$clog2(NUM_REQ)`. Wrap-around from `NUM_REQ`-1 to 0 is explicit, since `NUM_REQ` need not be a power of 2.
- `dec_W` shows `w_q` in all states; reset value 0.

## Timing
- Reset (`rst_n`=0 sampled at a rising edge) takes effect at that edge:
  - state=IDLE, `rr_ptr`=0, `gnt_q`=0, `w_q`=0, `n_q`=0, `err_q`=0, `wait_cnt`=0.
  - `req_ready`=0, `rsp_valid`=0, `rsp_N`=0, `rsp_err`=0, `dec_W`=0, `busy`=0.
  - `dec_rst_n`=0 while `rst_n`=0, so the decoder is held in reset too.
- Reset mid-transaction (LAUNCH, WAIT or RESP) drops the request silently. No response is issued.
- Cycle numbering:
  - Accept handshake at edge E0; LAUNCH between E0 and E1.
  - WAIT cycle k (k≥1) ends at edge E(1+k).
- If `dec_found` is first high in WAIT cycle k, `rsp_valid` rises after edge E(1+k). Minimum accept-to-`rsp_valid` is 2 cycles.
- With no `found`, `rsp_valid` with `rsp_err`=1 rises after edge E(1+`TIMEOUT`).
- After the response handshake at edge Er, the next acceptance can occur at edge Er+1. The minimum back-to-back period is 4 cycles.
- `req_ready` is a combinational function of `req_valid`, `rr_ptr` and state. All other outputs are registered or decoded from registered state.

## Structure
- Shared package `sec_decode_pkg`:
  - state enum (`ST_IDLE`, `ST_LAUNCH`, `ST_WAIT`, `ST_RESP`);
  - `SEC_W_BITS`=61, `SEC_N_BITS`=53, `SEC_ALL_ONES_N`=53'h0F_FFFF_FFFF_FFFF.
- One sub-module: `rr_arbiter`, a combinational round-robin grant (inputs `req`, `ptr`; outputs one-hot `gnt`, `gnt_idx`, `any`).
- FSM, counters and data registers stay in the top module.
- The decoder is not instantiated inside this block; the integration top connects it.

## Test plan
All scenarios use a behavioural decoder model that raises `found` with `dec_N`=4503599627370495 in the D-th WAIT cycle after `dec_rst_n` release.
- **Single request, D=5:** requester 0 sends W=61'd123. Required: `dec_rst_n` low for exactly 1 cycle, `dec_W`=123, `rsp_valid`=4'b0001 after edge E6, `rsp_N`=4503599627370495, `rsp_err`=0.
- **Round-robin, D=2, `rsp_ready` tied 1:** all four `req_valid` high from reset. Required: grant order 0,1,2,3,0,1, with each transaction 5 cycles accept-to-accept.
- **Timeout, TIMEOUT=8, decoder never raises found:** Required: `rsp_err`=1, `rsp_N`=0, `rsp_valid` after E9.
- **Found/timeout collision, D=TIMEOUT:** Required: `rsp_err`=0, `rsp_N`=4503599627370495.
- **Backpressure:** `rsp_ready` held 0 for 10 cycles during RESP. Required: `rsp_valid`, `rsp_N` and `rsp_err` held stable; `req_ready`=0 throughout; `dec_rst_n`=1.
- **Reset mid-WAIT (cycle 3):** Required: all outputs take their reset values at that edge, `dec_rst_n`=0, no `rsp_valid` for the dropped request, and the next grant after reset goes to requester 0.
